one_wire_multi_master: RTL and testbench
========================================

Name: one_wire_multi_master

Overview:
- Byte-capable, multi-channel 1-Wire master that generalises the bit-level 1-Wire master.
- Accepts commands through a valid/ready handshake: reset/presence, write 1–8 bits, read 1–8 bits.
- Targets any of NUM_CH independent open-drain buses, at standard or overdrive speed.
- Sits between the command/packet decoder and the board 1-Wire pins; returns one response per command.

Parameters:
- CLK_FREQ, 60_000_000, system clock in Hz. Must be a multiple of 4_000_000.
- NUM_CH, 4, number of independent 1-Wire buses (1..16).
- CH_W, 2, width of channel index; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE and not in reset
- cmd_op  in  2  0=RESET, 1=WRITE, 2=READ, 3=illegal
- cmd_ch  in  CH_W  target channel
- cmd_nbits  in  4  bits to transfer, LSB first; 0 or >8 treated as 8
- cmd_wdata  in  8  write data; bit i sent in slot i
- cmd_od  in  1  1=overdrive timing for this command
- rsp_valid  out  1  one-cycle pulse when command completes
- rsp_rdata  out  8  read bits (bit i = slot i); unused upper bits 0; 0 for RESET/WRITE
- rsp_presence  out  1  RESET only: presence seen; 0 otherwise
- rsp_err  out  1  illegal op or cmd_ch >= NUM_CH
- rsp_ch  out  CH_W  channel of the completed command
- busy  out  1  high from acceptance until the rsp_valid cycle, inclusive
- onewire_io  inout  NUM_CH  open-drain buses; driven 0 when enabled, else 'z'

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, all buses released, state IDLE, timers and shift registers cleared.
  - Reset mid-operation releases the bus on that edge, discards the operation and emits no response.
- Acceptance: on cmd_valid & cmd_ready, latch op, ch, nbits, wdata, od. busy=1 from the next cycle.
- Error path: illegal op or channel out of range → no bus activity; rsp_valid with rsp_err=1 on the cycle after acceptance.
- Timebase: QDIV = CLK_FREQ/4_000_000 cycles per quarter-µs tick (q). The prescaler restarts on every state entry, so a phase of N q lasts exactly N*QDIV cycles.
- Input sampling: each onewire_io bit passes through a 2-FF synchronizer; all samples use the synchronized value.
- Phase durations in q, written as standard/overdrive:
  - RST_LOW 1920/280
  - RST_WAIT 280/34
  - RST_SAMPLE 32/8
  - RST_REC 1600/160
  - write-0 low 240/30, write-1 low 24/4
  - read low 24/4, read release-to-sample 36/4
  - slot recovery to end of slot 20/10
- States:
  - IDLE
  - RST_LOW (drive) → RST_WAIT (release) → RST_SAMPLE: presence flag set on any cycle the sync input is 0 → RST_REC → RESP
  - SLOT_LOW (drive; duration from op and current bit) → SLOT_HIGH (release)
    - WRITE: SLOT_HIGH lasts 0 q.
    - READ: SLOT_HIGH lasts the release-to-sample time; sample on its final cycle into rdata[bit_idx].
  - → SLOT_REC → if bit_idx == nbits-1 then RESP, else bit_idx+1 and back to SLOT_LOW.
  - RESP: one cycle; rsp_* fields valid with rsp_valid; then IDLE.
- rsp_* fields hold their values until the next rsp_valid.
- Only the latched channel is ever driven; all other channels always release.
- A zero-length phase is skipped; entering the next state consumes no extra cycle.
- cmd_valid while busy is ignored (not queued). Inputs are latched at acceptance, so changes while busy have no effect.

Test Plan:
- CLK_FREQ=4 MHz (QDIV=1), NUM_CH=4. RESET ch2, std, slave model pulls low 100 q after release for 480 q → ch2 low exactly 1920 cycles, other channels 'z'; rsp_presence=1, rsp_ch=2, rsp_err=0; busy spans acceptance+1 through RESP.
- RESET ch0 std with no slave → rsp_presence=0.
- RESET ch0 overdrive → low exactly 280 cycles.
- WRITE ch1 nbits=8, wdata=0xA5, std → low pulses in slot order 24,240,24,240,240,24,240,24 cycles; rsp_rdata=0.
- READ ch3 nbits=4, slave returns 1,0,1,1 (holds low through sample for 0) → rsp_rdata=0x0D.
- READ nbits=0 → 8 slots.
- Errors: cmd_ch=5 or cmd_op=3 → no bus activity; rsp_valid on the cycle after acceptance with rsp_err=1.
- cmd_valid held during busy → second command accepted only after rsp_valid.
- Assert rst mid-WRITE while driving low → bus 'z' on next edge, no rsp_valid; cmd_ready=1 after rst deasserts.

Source files
------------

// File: rtl/one_wire_multi_master.sv
// Multi-channel 1-Wire master: reset/presence, write and read of 1..8 bits per command,
// standard or overdrive timing, one response per accepted command.
module one_wire_multi_master #(
    parameter int CLK_FREQ = 60_000_000,
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [CH_W-1:0] cmd_ch,
    input  logic [3:0]      cmd_nbits,
    input  logic [7:0]      cmd_wdata,
    input  logic            cmd_od,
    output logic            rsp_valid,
    output logic [7:0]      rsp_rdata,
    output logic            rsp_presence,
    output logic            rsp_err,
    output logic [CH_W-1:0] rsp_ch,
    output logic            busy,
    inout  wire [NUM_CH-1:0] onewire_io
);

    localparam int QDIV = CLK_FREQ / 4_000_000;
    localparam int PW   = (QDIV > 1) ? $clog2(QDIV) : 1;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_LOW,
        S_RST_WAIT,
        S_RST_SAMPLE,
        S_RST_REC,
        S_SLOT_LOW,
        S_SLOT_HIGH,
        S_SLOT_REC,
        S_RESP
    } state_t;

    state_t state, next_state;

    logic [1:0]      op_q;
    logic [CH_W-1:0] ch_q;
    logic [2:0]      last_idx;
    logic [7:0]      wdata_q;
    logic            od_q;
    logic [2:0]      bit_idx;
    logic [7:0]      rdata;
    logic            presence;
    logic [PW-1:0]   presc;
    logic [10:0]     qcnt;
    logic [10:0]     dur;
    logic            phase_done;
    logic            accept;
    logic            err_now;
    logic            sync_bit;
    logic            drive_low;
    logic [NUM_CH-1:0] sync1, sync2, drv;

    // Handshake: a command transfers on the rising edge where cmd_valid and cmd_ready
    // are both high; cmd_ready is high only in IDLE outside reset, nothing is queued.
    assign cmd_ready = (state == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign err_now   = (cmd_op == 2'd3) || (int'(cmd_ch) >= NUM_CH);
    assign busy      = (state != S_IDLE);

    always_comb begin
        dur = 11'd1;
        case (state)
            S_RST_LOW:    dur = od_q ? 11'd280 : 11'd1920;
            S_RST_WAIT:   dur = od_q ? 11'd34  : 11'd280;
            S_RST_SAMPLE: dur = od_q ? 11'd8   : 11'd32;
            S_RST_REC:    dur = od_q ? 11'd160 : 11'd1600;
            S_SLOT_LOW: begin
                if (op_q == OP_WRITE && !wdata_q[bit_idx])
                    dur = od_q ? 11'd30 : 11'd240;
                else
                    dur = od_q ? 11'd4 : 11'd24;
            end
            S_SLOT_HIGH:  dur = od_q ? 11'd4  : 11'd36;
            S_SLOT_REC:   dur = od_q ? 11'd10 : 11'd20;
            default:      dur = 11'd1;
        endcase
    end

    assign phase_done = (presc == PW'(QDIV - 1)) && (qcnt == dur - 11'd1);

    always_comb begin
        sync_bit = 1'b1;
        drv      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) begin
                sync_bit = sync2[i];
                drv[i]   = drive_low;
            end
        end
    end

    assign drive_low = (state == S_RST_LOW) || (state == S_SLOT_LOW);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pad
        assign onewire_io[g] = drv[g] ? 1'b0 : 1'bz;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (err_now)                next_state = S_RESP;
                    else if (cmd_op == OP_RESET) next_state = S_RST_LOW;
                    else                        next_state = S_SLOT_LOW;
                end
            end
            S_RST_LOW:    if (phase_done) next_state = S_RST_WAIT;
            S_RST_WAIT:   if (phase_done) next_state = S_RST_SAMPLE;
            S_RST_SAMPLE: if (phase_done) next_state = S_RST_REC;
            S_RST_REC:    if (phase_done) next_state = S_RESP;
            // Writes have no release-to-sample phase, so they go straight to recovery.
            S_SLOT_LOW:   if (phase_done) next_state = (op_q == OP_READ) ? S_SLOT_HIGH : S_SLOT_REC;
            S_SLOT_HIGH:  if (phase_done) next_state = S_SLOT_REC;
            S_SLOT_REC:   if (phase_done) next_state = (bit_idx == last_idx) ? S_RESP : S_SLOT_LOW;
            S_RESP:       next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sync1 <= '1;
            sync2 <= '1;
            presc <= '0;
            qcnt  <= '0;
        end else begin
            state <= next_state;
            sync1 <= onewire_io;
            sync2 <= sync1;
            // Prescaler restarts on each state change so a phase is exactly dur*QDIV cycles.
            if (next_state != state) begin
                presc <= '0;
                qcnt  <= '0;
            end else if (presc == PW'(QDIV - 1)) begin
                presc <= '0;
                qcnt  <= qcnt + 11'd1;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            ch_q     <= '0;
            last_idx <= '0;
            wdata_q  <= '0;
            od_q     <= 1'b0;
            bit_idx  <= '0;
            rdata    <= '0;
            presence <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= cmd_op;
                ch_q     <= cmd_ch;
                last_idx <= (cmd_nbits == 4'd0 || cmd_nbits > 4'd8) ? 3'd7 : 3'(cmd_nbits - 4'd1);
                wdata_q  <= cmd_wdata;
                od_q     <= cmd_od;
                bit_idx  <= '0;
                rdata    <= '0;
                presence <= 1'b0;
            end
            if (state == S_RST_SAMPLE && !sync_bit)
                presence <= 1'b1;
            if (state == S_SLOT_HIGH && phase_done)
                rdata[bit_idx] <= sync_bit;
            if (state == S_SLOT_REC && phase_done && bit_idx != last_idx)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_presence <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_ch       <= '0;
        end else begin
            rsp_valid <= (next_state == S_RESP);
            if (next_state == S_RESP) begin
                rsp_err      <= (state == S_IDLE);
                rsp_ch       <= (state == S_IDLE) ? cmd_ch : ch_q;
                rsp_presence <= (state == S_RST_REC) && presence;
                rsp_rdata    <= (state == S_SLOT_REC && op_q == OP_READ) ? rdata : 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_one_wire_multi_master.sv
// Directed bench for one_wire_multi_master at 4 MHz (one clock per quarter-microsecond),
// with simple presence/read slave behaviour driven from the stimulus thread.
module tb_one_wire_multi_master;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_op = '0;
    logic [CH_W-1:0] cmd_ch = '0;
    logic [3:0]      cmd_nbits = '0;
    logic [7:0]      cmd_wdata = '0;
    logic            cmd_od = 1'b0;
    logic            rsp_valid;
    logic [7:0]      rsp_rdata;
    logic            rsp_presence;
    logic            rsp_err;
    logic [CH_W-1:0] rsp_ch;
    logic            busy;
    wire  [NUM_CH-1:0] ow;
    logic [NUM_CH-1:0] slv_low = '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_bus
        pullup (ow[g]);
        assign ow[g] = slv_low[g] ? 1'b0 : 1'bz;
    end

    one_wire_multi_master #(
        .CLK_FREQ(4_000_000),
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_ch      (cmd_ch),
        .cmd_nbits   (cmd_nbits),
        .cmd_wdata   (cmd_wdata),
        .cmd_od      (cmd_od),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_presence(rsp_presence),
        .rsp_err     (rsp_err),
        .rsp_ch      (rsp_ch),
        .busy        (busy),
        .onewire_io  (ow)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    int busy_total = 0;
    int rsp_cnt = 0;
    int rsp_cyc = 0;
    int low_run [NUM_CH] = '{default: 0};
    int pulse_ch [$];
    int pulse_len [$];

    always @(negedge clk) begin
        if (busy) busy_total <= busy_total + 1;
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            rsp_cyc <= cyc;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ow[i] === 1'b0) begin
                low_run[i] <= low_run[i] + 1;
            end else if (low_run[i] != 0) begin
                pulse_ch.push_back(i);
                pulse_len.push_back(low_run[i]);
                low_run[i] <= 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int count_other(input int ch);
        int n = 0;
        foreach (pulse_ch[i]) if (pulse_ch[i] != ch) n++;
        return n;
    endfunction

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;
    int busy_base = 0;

    task automatic send_cmd(input logic [1:0] op, input logic [CH_W-1:0] ch,
                            input logic [3:0] nbits, input logic [7:0] wdata, input logic od);
        @(negedge clk);
        cmd_op = op; cmd_ch = ch; cmd_nbits = nbits; cmd_wdata = wdata; cmd_od = od;
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                acc_cyc   = cyc;
                busy_base = busy_total;
                @(posedge clk);
                #1 cmd_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input int limit);
        int prev;
        prev = rsp_cnt;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rsp_cnt != prev) return;
        end
        check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bus(input int ch, input logic val, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ow[ch] === val) return;
        end
        check("bus_timeout", 32'(ch), 32'(val));
    endtask

    task automatic clear_pulses();
        pulse_ch.delete();
        pulse_len.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int acc1;
        int acc2;
        int r0;
        int sum;
        logic [3:0] rd_bits;

        repeat (4) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_bus", 32'(ow), 32'hF);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);

        // RESET ch2 standard with a presence pulse 100 q after release, 480 q long
        clear_pulses();
        send_cmd(2'd0, 3'd2, 4'd0, 8'h00, 1'b0);
        wait_bus(2, 1'b0, 10);
        wait_bus(2, 1'b1, 2100);
        repeat (100) @(negedge clk);
        slv_low[2] = 1'b1;
        repeat (480) @(negedge clk);
        slv_low[2] = 1'b0;
        wait_rsp(4000);
        check("rst2_presence", 32'(rsp_presence), 32'd1);
        check("rst2_ch", 32'(rsp_ch), 32'd2);
        check("rst2_err", 32'(rsp_err), 32'd0);
        check("rst2_latency", 32'(rsp_cyc - acc_cyc), 32'd3833);
        check("rst2_busy_cycles", 32'(busy_total - busy_base), 32'd3833);
        check("rst2_low_len", (pulse_len.size() > 0) ? 32'(pulse_len[0]) : 32'd0, 32'd1920);
        check("rst2_low_ch", (pulse_ch.size() > 0) ? 32'(pulse_ch[0]) : 32'd99, 32'd2);
        check("rst2_other_ch", 32'(count_other(2)), 32'd0);
        repeat (5) @(negedge clk);
        check("rst2_hold_presence", 32'(rsp_presence), 32'd1);

        // RESET ch0 standard, nobody answers
        clear_pulses();
        send_cmd(2'd0, 3'd0, 4'd0, 8'h00, 1'b0);
        wait_rsp(4000);
        check("rst0_presence", 32'(rsp_presence), 32'd0);
        check("rst0_ch", 32'(rsp_ch), 32'd0);

        // RESET ch0 overdrive
        clear_pulses();
        send_cmd(2'd0, 3'd0, 4'd0, 8'h00, 1'b1);
        wait_rsp(1000);
        check("rstod_low_len", (pulse_len.size() > 0) ? 32'(pulse_len[0]) : 32'd0, 32'd280);
        check("rstod_latency", 32'(rsp_cyc - acc_cyc), 32'd483);
        check("rstod_presence", 32'(rsp_presence), 32'd0);

        // WRITE ch1 0xA5 standard: LSB first 1,0,1,0,0,1,0,1
        clear_pulses();
        exp_q = '{32'd24, 32'd240, 32'd24, 32'd240, 32'd240, 32'd24, 32'd240, 32'd24};
        send_cmd(2'd1, 3'd1, 4'd8, 8'hA5, 1'b0);
        wait_rsp(2000);
        check("wr_pulse_count", 32'(pulse_len.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wr_slot%0d_low", i),
                  (i < pulse_len.size()) ? 32'(pulse_len[i]) : 32'd0, exp_q.pop_front());
        end
        check("wr_other_ch", 32'(count_other(1)), 32'd0);
        check("wr_rdata", 32'(rsp_rdata), 32'd0);
        check("wr_latency", 32'(rsp_cyc - acc_cyc), 32'd1217);
        check("wr_ch", 32'(rsp_ch), 32'd1);

        // READ ch3 nbits=4, slave returns 1,0,1,1
        clear_pulses();
        rd_bits = 4'b1101;
        send_cmd(2'd2, 3'd3, 4'd4, 8'h00, 1'b0);
        for (int s = 0; s < 4; s++) begin
            wait_bus(3, 1'b0, 200);
            if (!rd_bits[s]) begin
                slv_low[3] = 1'b1;
                repeat (70) @(negedge clk);
                slv_low[3] = 1'b0;
            end
            wait_bus(3, 1'b1, 200);
        end
        wait_rsp(400);
        check("rd4_rdata", 32'(rsp_rdata), 32'h0D);
        check("rd4_latency", 32'(rsp_cyc - acc_cyc), 32'd321);
        check("rd4_ch", 32'(rsp_ch), 32'd3);

        // READ nbits=0 means 8 slots; idle bus reads all ones
        clear_pulses();
        send_cmd(2'd2, 3'd1, 4'd0, 8'h00, 1'b0);
        wait_rsp(1000);
        sum = 0;
        foreach (pulse_len[i]) sum += pulse_len[i];
        check("rd8_rdata", 32'(rsp_rdata), 32'hFF);
        check("rd8_pulse_count", 32'(pulse_len.size()), 32'd8);
        check("rd8_low_total", 32'(sum), 32'd192);
        check("rd8_latency", 32'(rsp_cyc - acc_cyc), 32'd641);

        // Error paths: channel out of range, boundary channel, illegal op
        clear_pulses();
        send_cmd(2'd1, 3'd5, 4'd8, 8'h00, 1'b0);
        wait_rsp(10);
        check("err_ch5_err", 32'(rsp_err), 32'd1);
        check("err_ch5_ch", 32'(rsp_ch), 32'd5);
        check("err_ch5_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
        check("err_ch5_rdata", 32'(rsp_rdata), 32'd0);
        send_cmd(2'd2, 3'd4, 4'd1, 8'h00, 1'b0);
        wait_rsp(10);
        check("err_ch4_err", 32'(rsp_err), 32'd1);
        check("err_ch4_latency", 32'(rsp_cyc - acc_cyc), 32'd1);
        send_cmd(2'd3, 3'd0, 4'd1, 8'h00, 1'b0);
        wait_rsp(10);
        check("err_op3_err", 32'(rsp_err), 32'd1);
        check("err_op3_busy_cycles", 32'(busy_total - busy_base), 32'd1);
        repeat (5) @(negedge clk);
        check("err_no_bus_activity", 32'(pulse_len.size()), 32'd0);

        // Valid held through busy: second accept only after the response
        @(negedge clk);
        cmd_op = 2'd1; cmd_ch = 3'd0; cmd_nbits = 4'd1; cmd_wdata = 8'h01; cmd_od = 1'b1;
        cmd_valid = 1'b1;
        check("hold_ready_first", 32'(cmd_ready), 32'd1);
        acc1 = cyc;
        r0 = rsp_cnt;
        @(negedge clk);
        check("hold_ready_busy", 32'(cmd_ready), 32'd0);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        acc2 = cyc;
        check("hold_second_accept", 32'(acc2 - acc1), 32'd16);
        check("hold_one_rsp", 32'(rsp_cnt - r0), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rsp(50);
        check("hold_two_rsp", 32'(rsp_cnt - r0), 32'd2);

        // Reset in the middle of a write low phase
        send_cmd(2'd1, 3'd1, 4'd8, 8'h00, 1'b0);
        wait_bus(1, 1'b0, 10);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        r0 = rsp_cnt;
        @(posedge clk);
        #1;
        check("midrst_bus_released", 32'(ow[1]), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_cnt - r0), 32'd0);
        check("midrst_ready_after", 32'(cmd_ready), 32'd1);
        check("midrst_bus_idle", 32'(ow), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
